// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller: FSM state encoding,
// default parameter values and the phase-timer width helper.
package sar_pkg;

  localparam int SAR_N_BITS_DEF        = 10;
  localparam int SAR_SAMPLE_CYCLES_DEF = 4;
  localparam int SAR_SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_TRIAL  = 2'd2,
    S_DONE   = 2'd3
  } sar_state_e;

  // Width of the shared phase timer: it must hold the longer of the two
  // phase lengths.
  function automatic int sar_timer_width(input int sample_cycles, input int settle_cycles);
    int longest;
    longest = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter shared by the SAMPLE and TRIAL phases. Loading a
// value V makes expire pulse V+1 cycles later (load of 0 -> expire in the
// very next cycle). expire is a single-cycle pulse per load.
module sar_phase_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          expire
);

  logic [TW-1:0] r_count;
  logic          r_active;

  assign expire = r_active && (r_count == {TW{1'b0}});

  // Count down from the loaded value; disarm once the count reaches zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= {TW{1'b0}};
      r_active <= 1'b0;
    end else if (load) begin
      r_count  <= load_value;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == {TW{1'b0}}) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_count  <= r_count;
      r_active <= r_active;
    end
  end

endmodule

// File: rtl/sar_conversion_controller.sv
// Successive-approximation conversion controller: track phase, then one
// binary-search trial per bit (MSB first), then a one-cycle done strobe.
// All outputs are registered from next-state values so they change
// cleanly on the clock edge.
module sar_conversion_controller
  import sar_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS_DEF,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp_in,
  output logic              sample,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int TW = sar_timer_width(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB     = IW'(N_BITS - 1);
  localparam logic [IW-1:0] IDX_ZERO    = IW'(0);
  localparam logic [IW-1:0] IDX_ONE     = IW'(1);

  sar_state_e        r_state;
  sar_state_e        w_state_nxt;
  logic [IW-1:0]     r_bit_idx;
  logic [IW-1:0]     w_bit_idx_nxt;
  logic [N_BITS-1:0] r_code;
  logic [N_BITS-1:0] w_code_nxt;
  logic [N_BITS-1:0] w_code_decided;
  logic [N_BITS-1:0] r_result;
  logic [N_BITS-1:0] w_result_nxt;
  logic              r_sample;
  logic              r_busy;
  logic              r_done;
  logic              w_sample_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_abort_hit;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_value;
  logic              w_tmr_expire;

  assign w_abort_hit = abort && (r_state != S_IDLE);

  sar_phase_timer #(
    .TW (TW)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .expire     (w_tmr_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort_hit) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) w_state_nxt = S_SAMPLE;
          else       w_state_nxt = S_IDLE;
        end
        S_SAMPLE: begin
          if (w_tmr_expire) w_state_nxt = S_TRIAL;
          else              w_state_nxt = S_SAMPLE;
        end
        S_TRIAL: begin
          if (w_tmr_expire && (r_bit_idx == IDX_ZERO)) w_state_nxt = S_DONE;
          else                                          w_state_nxt = S_TRIAL;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state, registered below.
  always_comb begin
    w_sample_nxt = (w_state_nxt == S_SAMPLE);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_done_nxt   = (w_state_nxt == S_DONE);
  end

  // Trial datapath: decide the current bit, arm the next one, load the timer.
  always_comb begin
    w_code_nxt     = r_code;
    w_bit_idx_nxt  = r_bit_idx;
    w_result_nxt   = r_result;
    w_tmr_load     = 1'b0;
    w_tmr_value    = {TW{1'b0}};
    // Current bit survives only if the comparator says input >= DAC level.
    w_code_decided = r_code;
    w_code_decided[r_bit_idx] = r_code[r_bit_idx] & cmp_in;
    if (w_abort_hit) begin
      w_code_nxt    = {N_BITS{1'b0}};
      w_bit_idx_nxt = IDX_MSB;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_code_nxt    = {N_BITS{1'b0}};
            w_bit_idx_nxt = IDX_MSB;
            w_tmr_load    = 1'b1;
            w_tmr_value   = SAMPLE_LOAD;
          end else begin
            w_code_nxt = r_code;
          end
        end
        S_SAMPLE: begin
          if (w_tmr_expire) begin
            w_code_nxt             = {N_BITS{1'b0}};
            w_code_nxt[N_BITS-1]   = 1'b1;
            w_bit_idx_nxt          = IDX_MSB;
            w_tmr_load             = 1'b1;
            w_tmr_value            = SETTLE_LOAD;
          end else begin
            w_code_nxt = r_code;
          end
        end
        S_TRIAL: begin
          if (w_tmr_expire) begin
            w_code_nxt = w_code_decided;
            if (r_bit_idx != IDX_ZERO) begin
              w_code_nxt[r_bit_idx - IDX_ONE] = 1'b1;
              w_bit_idx_nxt = r_bit_idx - IDX_ONE;
              w_tmr_load    = 1'b1;
              w_tmr_value   = SETTLE_LOAD;
            end else begin
              w_result_nxt = w_code_decided;
            end
          end else begin
            w_code_nxt = r_code;
          end
        end
        S_DONE: begin
          w_code_nxt    = r_code;
          w_bit_idx_nxt = IDX_MSB;
        end
        default: begin
          w_code_nxt    = {N_BITS{1'b0}};
          w_bit_idx_nxt = IDX_MSB;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_idx <= IDX_MSB;
      r_code    <= {N_BITS{1'b0}};
      r_result  <= {N_BITS{1'b0}};
      r_sample  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bit_idx <= w_bit_idx_nxt;
      r_code    <= w_code_nxt;
      r_result  <= w_result_nxt;
      r_sample  <= w_sample_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign sample   = r_sample;
  assign dac_code = r_code;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;

endmodule

// File: tb/tb_sar_conversion_controller.sv
// Self-checking bench for sar_conversion_controller. Two instances: the
// default configuration and a fast one (SAMPLE_CYCLES=1, SETTLE_CYCLES=1).
// An ideal comparator (vin >= dac_code) closes the loop; expected results
// and done cycles are queued at start and popped when done is seen.
module tb_sar_conversion_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sel = 1'b0;
  logic [9:0] vin = 10'd0;

  logic       d1_sample, d1_busy, d1_done, d1_cmp;
  logic [9:0] d1_dac, d1_result;
  logic       d2_sample, d2_busy, d2_done, d2_cmp;
  logic [9:0] d2_dac, d2_result;

  logic       o_sample, o_busy, o_done;
  logic [9:0] o_dac, o_result;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_res_q[$];
  int         exp_cyc_q[$];

  always #5 clk = ~clk;

  assign d1_cmp = (vin >= d1_dac);
  assign d2_cmp = (vin >= d2_dac);

  assign o_sample = sel ? d2_sample : d1_sample;
  assign o_busy   = sel ? d2_busy   : d1_busy;
  assign o_done   = sel ? d2_done   : d1_done;
  assign o_dac    = sel ? d2_dac    : d1_dac;
  assign o_result = sel ? d2_result : d1_result;

  sar_conversion_controller #(
    .N_BITS (10), .SAMPLE_CYCLES (4), .SETTLE_CYCLES (2)
  ) u_dut_def (
    .clk (clk), .reset (reset), .start (start && !sel), .abort (abort && !sel),
    .cmp_in (d1_cmp), .sample (d1_sample), .dac_code (d1_dac), .busy (d1_busy),
    .done (d1_done), .result (d1_result)
  );

  sar_conversion_controller #(
    .N_BITS (10), .SAMPLE_CYCLES (1), .SETTLE_CYCLES (1)
  ) u_dut_fast (
    .clk (clk), .reset (reset), .start (start && sel), .abort (abort && sel),
    .cmp_in (d2_cmp), .sample (d2_sample), .dac_code (d2_dac), .busy (d2_busy),
    .done (d2_done), .result (d2_result)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard head and compare against the observed done event.
  task automatic score_done(input int cyc);
    logic [9:0] er;
    int         ec;
    if (exp_res_q.size() == 0) begin
      check_vec("unexpected_done", 32'd1, 32'd0);
    end else begin
      er = exp_res_q.pop_front();
      ec = exp_cyc_q.pop_front();
      check_vec("result", o_result, er);
      check_vec("done_cycle", cyc, ec);
      check_vec("dac_hold_final", o_dac, er);
    end
  endtask

  // One conversion of v; checks track phase, every trial code and done.
  task automatic convert(input logic [9:0] v, input int s_cyc, input int t_cyc);
    int         c;
    int         k;
    int         mask;
    logic [9:0] exp_code;
    bit         seen;
    vin = v;
    exp_res_q.push_back(v);
    exp_cyc_q.push_back(1 + s_cyc + 10 * t_cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 60) begin
      if (c <= s_cyc) begin
        check_vec("track_sample", o_sample, 1);
        check_vec("track_dac", o_dac, 0);
      end else if (c <= s_cyc + 10 * t_cyc) begin
        k = 9 - (c - 1 - s_cyc) / t_cyc;
        mask = ~((1 << (k + 1)) - 1);
        exp_code = (v & mask[9:0]) | 10'(1 << k);
        check_vec("trial_dac", o_dac, exp_code);
        check_vec("trial_sample", o_sample, 0);
      end
      check_vec("busy_in_conv", o_busy, 1);
      if (o_done) begin
        seen = 1'b1;
        score_done(c);
      end else begin
        tick();
        c++;
      end
    end
    if (!seen) check_vec("done_timeout", 32'd0, 32'd1);
    tick();
    check_vec("done_one_cycle", o_done, 0);
    check_vec("idle_after_done", o_busy, 0);
  endtask

  // start held high: conversions every 26 cycles, nothing extra queued.
  task automatic back_to_back();
    int c;
    int ndone;
    vin = 10'd300;
    for (int i = 0; i < 3; i++) begin
      exp_res_q.push_back(10'd300);
      exp_cyc_q.push_back(25 + 26 * i);
    end
    start = 1'b1;
    tick();
    c = 1;
    ndone = 0;
    while (c <= 80) begin
      if (o_done) begin
        ndone++;
        score_done(c);
      end
      if (c == 77) start = 1'b0;
      tick();
      c++;
    end
    check_vec("b2b_done_count", ndone, 3);
    check_vec("b2b_queue_empty", exp_res_q.size(), 0);
    check_vec("b2b_idle", o_busy, 0);
  endtask

  // Abort in cycle 12 (mid-trial): IDLE next cycle, result retained.
  task automatic abort_mid(input logic [9:0] prev);
    int ndone;
    vin = 10'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_vec("abort_busy", o_busy, 0);
    check_vec("abort_dac", o_dac, 0);
    check_vec("abort_sample", o_sample, 0);
    check_vec("abort_done", o_done, 0);
    check_vec("abort_result", o_result, prev);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_done) ndone++;
      tick();
    end
    check_vec("abort_no_done", ndone, 0);
    // abort while idle changes nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_vec("idle_abort_busy", o_busy, 0);
    check_vec("idle_abort_result", o_result, prev);
  endtask

  // Asynchronous reset in cycle 9 clears outputs before any clock edge.
  task automatic reset_mid();
    vin = 10'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check_vec("pre_reset_busy", o_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_vec("rst_sample", o_sample, 0);
    check_vec("rst_busy", o_busy, 0);
    check_vec("rst_done", o_done, 0);
    check_vec("rst_dac", o_dac, 0);
    check_vec("rst_result", o_result, 0);
    tick();
    reset = 1'b1;
    tick();
    check_vec("post_rst_busy", o_busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_sample", o_sample, 0);
    check_vec("reset_busy", o_busy, 0);
    check_vec("reset_done", o_done, 0);
    check_vec("reset_dac", o_dac, 0);
    check_vec("reset_result", o_result, 0);
    reset = 1'b1;
    tick();

    convert(10'd677, 4, 2);
    convert(10'd0, 4, 2);
    convert(10'd1023, 4, 2);
    convert(10'd677, 4, 2);
    back_to_back();
    convert(10'd677, 4, 2);
    abort_mid(10'd677);
    reset_mid();
    convert(10'd677, 4, 2);

    sel = 1'b1;
    tick();
    check_vec("fast_reset_result", o_result, 0);
    convert(10'd677, 1, 1);
    convert(10'd341, 1, 1);
    check_vec("queue_drained", exp_res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sar_conversion_controller.md
# sar_conversion_controller

Successive-approximation control stage that closes the loop between the behavioural comparator and the fixed-point DAC output model. It consumes the comparator's `out_digital` decision and drives the `in_digital` code of the DAC stage, so that the DAC's `out_analog` becomes the comparator's reference voltage. Each conversion runs as a track phase followed by one binary-search trial per bit, MSB first. It delivers an N-bit result with a one-cycle done strobe.

## Interface
- `N_BITS`, default 10: resolution; width of `dac_code` and `result`.
- `SAMPLE_CYCLES`, default 4: cycles `sample` is held high per conversion; legal range is ≥1.
- `SETTLE_CYCLES`, default 2: cycles each trial code is held before the comparator is read; legal range is ≥1.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  conversion request; sampled only in IDLE.
- `abort`  input  1  synchronous cancel; returns to IDLE without a done pulse.
- `cmp_in`  input  1  comparator decision: 1 means input ≥ DAC voltage (keep the bit), 0 means clear the bit.
- `sample`  output  1  high during the track phase.
- `dac_code`  output  N_BITS  trial code to the DAC stage.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when `result` updates.
- `result`  output  N_BITS  last completed conversion; held until the next done.

## Operation
- Reset (asynchronous, while `reset`=0) puts these values on the outputs:
  - state=IDLE;
  - `sample`=0, `busy`=0, `done`=0;
  - `dac_code`=0, `result`=0;
  - bit index=N_BITS-1, timer=0.
- FSM states and transitions:
  - IDLE → SAMPLE when `start`=1.
  - SAMPLE: `sample`=1 and `dac_code`=0. After SAMPLE_CYCLES cycles, go to TRIAL with k=N_BITS-1 and `dac_code` = 1<<k.
  - TRIAL: hold `dac_code` for SETTLE_CYCLES cycles. On the last cycle, read `cmp_in`:
    - if `cmp_in`=0, clear bit k;
    - if k>0, set bit k-1, decrement k and restart the timer;
    - if k=0, go to DONE.
  - DONE: `result` ← final code, `done`=1 for this cycle only; then go to IDLE. `dac_code` holds the final code until the next SAMPLE.
- Bits below k are always 0 in `dac_code` during trial k. Bits above k keep their decided values.
- `abort`=1 in any non-IDLE state forces IDLE on the next edge:
  - `dac_code`=0, `sample`=0;
  - `result` is unchanged and `done` is not asserted.
  - `abort` has priority over every other transition. `abort` in IDLE has no effect.
- `start` outside IDLE is ignored, including in the DONE cycle. No request is queued.
- The comparator is assumed settled within SETTLE_CYCLES; `cmp_in` is never read outside the last TRIAL cycle.

## Timing
- The edge that samples `start`=1 is cycle 0. `sample` is high in cycles 1..SAMPLE_CYCLES.
- Trial k (for k=N_BITS-1 down to 0) occupies SETTLE_CYCLES cycles. `cmp_in` is read on the final cycle of each trial.
- `done` is high in cycle 1+SAMPLE_CYCLES+N_BITS·SETTLE_CYCLES. With defaults this is cycle 25, and `result` is valid from that same cycle.
- Earliest restart: `start` sampled in cycle 26 (IDLE), so the conversion period is 26 cycles with defaults.
- A conversion interrupted by reset mid-flight produces no done pulse. `result` returns to 0.

## Structure
- Shared package `sar_pkg` holds:
  - the state enum (IDLE, SAMPLE, TRIAL, DONE);
  - a timer-width function, `$clog2(max(SAMPLE_CYCLES,SETTLE_CYCLES)+1)`;
  - the default parameter constants.
- One sub-module, `sar_phase_timer`: a loadable down-counter with a `load` input, a `load_value` input and an `expire` pulse. It is shared by the SAMPLE and TRIAL phases.
- The top level holds the FSM, the bit-index register and the code/result registers.

## Test plan
All scenarios use the defaults (N_BITS=10, SAMPLE_CYCLES=4, SETTLE_CYCLES=2). The bench comparator model is `cmp_in` = (vin ≥ `dac_code`), evaluated combinationally.
- vin=677 (0x2A5), pulse `start` → `dac_code` sequence 512, 768, 640, 704, 672, 688, 680, 676, 678, 677 (two cycles each); `done` in cycle 25; `result`=677.
- vin=0 and vin=1023 → `result`=0 and 1023 respectively. The all-zero case shows each bit being set then cleared; the all-one case shows every bit kept.
- `start` held high continuously → back-to-back conversions, with `done` every 26 cycles. `start` during busy and in the DONE cycle starts nothing extra.
- `abort` in cycle 12 (mid-TRIAL) → IDLE next cycle, `busy`=0, `dac_code`=0, no `done`, `result` keeps its previous value (677).
- `reset` deasserted-to-0 asynchronously in cycle 9 → all outputs at reset values immediately, without waiting for a clock edge. A fresh `start` after release converts correctly.
- SETTLE_CYCLES=1, SAMPLE_CYCLES=1 → `done` in cycle 12; `result` is identical to the default run for vin=677.
